// File: rtl/adc16dv160_rx.sv
// ADC16DV160 DDR receive deserializer with start/length capture control.
// Rise/fall byte pairs are re-interleaved into 16-bit samples and buffered in a FWFT FIFO.
module adc16dv160_rx #(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [7:0]                    d_rise,
    input  logic [7:0]                    d_fall,
    input  logic                          phase,
    input  logic                          start,
    input  logic [LEN_W-1:0]              len,
    output logic [15:0]                   m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [7:0]       f_prev;
    logic [7:0]       odd_b, even_b;
    logic [15:0]      word;
    logic             last_w;
    logic             wr_req, ovf_clr;
    logic             full, pop, wr_ok, drop;
    logic [16:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;

    // Falling-edge byte of the previous cycle, kept even while idle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) f_prev <= '0;
        else       f_prev <= d_fall;
    end

    // Pick odd/even bytes by pairing phase and interleave into a sample
    always_comb begin
        odd_b  = phase ? d_rise : f_prev;
        even_b = phase ? d_fall : d_rise;
        word   = '0;
        for (int k = 0; k < 8; k++) begin
            word[2*k+1] = odd_b[k];
            word[2*k]   = even_b[k];
        end
    end

    assign last_w = (cnt == LEN_W'(1));

    // Capture FSM state and sample counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter and control outputs
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_req    = 1'b0;
        ovf_clr   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    ovf_clr = 1'b1;
                    if (len != '0) begin
                        state_nxt = S_CAPTURE;
                        cnt_nxt   = len;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_CAPTURE: begin
                busy    = 1'b1;
                wr_req  = 1'b1;
                cnt_nxt = cnt - LEN_W'(1);
                if (last_w) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign full  = (count == FULL_C);
    assign pop   = m_valid && m_ready;
    assign wr_ok = wr_req && (!full || pop);
    assign drop  = wr_req && full && !pop;

    // FIFO storage of {last, word}; no reset needed, outputs are gated
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= {last_w, word};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_ok && !pop)      count <= count + (AW+1)'(1);
            else if (!wr_ok && pop) count <= count - (AW+1)'(1);
        end
    end

    // Sticky drop flag, cleared by an accepted start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        overflow <= 1'b0;
        else if (ovf_clr) overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
    end

    assign m_valid = (count != '0);
    assign m_data  = m_valid ? mem[rd_ptr][15:0] : 16'h0000;
    assign m_last  = m_valid && mem[rd_ptr][16];
    assign level   = count;

endmodule
